bn_seq_ctrl: RTL and testbench



---
 rtl/bn_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_bn_seq_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bn_seq_ctrl.sv
// Batch-norm sequencer: fetches per-channel (A,B) coefficients, streams pixels into the BN unit,
// tracks in-flight samples and tags the final result. Optional fused ReLU via `BN_RELU_EN.
module bn_seq_ctrl #(
    parameter int unsigned D_WL   = 24,
    parameter int unsigned CH_W   = 8,
    parameter int unsigned PIX_W  = 12,
    parameter int unsigned BN_LAT = 3
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CH_W-1:0]   cfg_ch_num,
    input  logic [PIX_W-1:0]  cfg_pix_num,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    input  logic [D_WL-1:0]   in_data,
    output logic              in_ready,
    output logic              coef_rd,
    output logic [CH_W-1:0]   coef_addr,
    input  logic [D_WL-1:0]   coef_a,
    input  logic [D_WL-1:0]   coef_b,
    output logic              bn_en,
    output logic [D_WL-1:0]   bn_din,
    output logic [D_WL-1:0]   bn_a,
    output logic [D_WL-1:0]   bn_b,
    input  logic              bn_o_valid,
    input  logic [D_WL-1:0]   bn_dout,
    output logic              out_valid,
    output logic [D_WL-1:0]   out_data,
    output logic              out_last
);

    localparam int unsigned IF_W = $clog2(BN_LAT + 1) + 1;

    localparam logic [CH_W-1:0]  ChOne  = 1;
    localparam logic [PIX_W-1:0] PixOne = 1;
    localparam logic [IF_W-1:0]  IfOne  = 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_num_q, ch_num_d;
    logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
    logic [PIX_W-1:0]  pix_num_q, pix_num_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [D_WL-1:0]   bn_a_q, bn_a_d;
    logic [D_WL-1:0]   bn_b_q, bn_b_d;
    logic [IF_W-1:0]   inflight_q, inflight_d;

    logic              last_pix;
    logic              last_ch;

    assign last_pix = (pix_cnt_q == pix_num_q - PixOne);
    assign last_ch  = (ch_cnt_q == ch_num_q - ChOne);

    // Samples entering the BN pipe minus results leaving it.
    always_comb begin
        inflight_d = inflight_q;
        unique case ({bn_en, bn_o_valid})
            2'b10:   inflight_d = inflight_q + IfOne;
            2'b01:   inflight_d = inflight_q - IfOne;
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ch_num_d  = ch_num_q;
        ch_cnt_d  = ch_cnt_q;
        pix_num_d = pix_num_q;
        pix_cnt_d = pix_cnt_q;
        bn_a_d    = bn_a_q;
        bn_b_d    = bn_b_q;
        coef_rd   = 1'b0;
        in_ready  = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_ch_num != '0 && cfg_pix_num != '0) begin
                        ch_num_d  = cfg_ch_num;
                        pix_num_d = cfg_pix_num;
                        ch_cnt_d  = '0;
                        pix_cnt_d = '0;
                        state_d   = StLoad;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StLoad: begin
                coef_rd = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                // RAM data is valid the cycle after the read strobe.
                bn_a_d  = coef_a;
                bn_b_d  = coef_b;
                state_d = StRun;
            end
            StRun: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (last_pix) begin
                        pix_cnt_d = '0;
                        if (last_ch) begin
                            state_d = StDrain;
                        end else begin
                            ch_cnt_d = ch_cnt_q + ChOne;
                            state_d  = StLoad;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + PixOne;
                    end
                end
            end
            StDrain: begin
                // Leave once the result retiring this cycle empties the pipe.
                if (inflight_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ch_num_q   <= '0;
            ch_cnt_q   <= '0;
            pix_num_q  <= '0;
            pix_cnt_q  <= '0;
            bn_a_q     <= '0;
            bn_b_q     <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_num_q   <= ch_num_d;
            ch_cnt_q   <= ch_cnt_d;
            pix_num_q  <= pix_num_d;
            pix_cnt_q  <= pix_cnt_d;
            bn_a_q     <= bn_a_d;
            bn_b_q     <= bn_b_d;
            inflight_q <= inflight_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign coef_addr = ch_cnt_q;
    assign bn_en     = in_ready && in_valid;
    assign bn_din    = in_data;
    assign bn_a      = bn_a_q;
    assign bn_b      = bn_b_q;
    assign out_valid = bn_o_valid;
    assign out_last  = bn_o_valid && (state_q == StDrain) && (inflight_q == IfOne);

`ifdef BN_RELU_EN
    assign out_data = bn_dout[D_WL-1] ? '0 : bn_dout;
`else
    assign out_data = bn_dout;
`endif

endmodule

// File: tb/tb_bn_seq_ctrl.sv
// Bench for bn_seq_ctrl: behavioural coefficient RAM and 3-cycle BN pipe, table-driven result
// checks plus directed sequences for zero-size, restart, abort and ReLU cases.
module tb_bn_seq_ctrl;

    localparam int D_WL   = 24;
    localparam int CH_W   = 8;
    localparam int PIX_W  = 12;
    localparam int BN_LAT = 3;

    logic              CLK = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CH_W-1:0]   cfg_ch_num;
    logic [PIX_W-1:0]  cfg_pix_num;
    logic              busy, done;
    logic              in_valid;
    logic [D_WL-1:0]   in_data;
    logic              in_ready;
    logic              coef_rd;
    logic [CH_W-1:0]   coef_addr;
    logic [D_WL-1:0]   coef_a, coef_b;
    logic              bn_en;
    logic [D_WL-1:0]   bn_din, bn_a, bn_b;
    logic              bn_o_valid;
    logic [D_WL-1:0]   bn_dout;
    logic              out_valid;
    logic [D_WL-1:0]   out_data;
    logic              out_last;

    bn_seq_ctrl #(
        .D_WL   (D_WL),
        .CH_W   (CH_W),
        .PIX_W  (PIX_W),
        .BN_LAT (BN_LAT)
    ) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_ch_num  (cfg_ch_num),
        .cfg_pix_num (cfg_pix_num),
        .busy        (busy),
        .done        (done),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .coef_rd     (coef_rd),
        .coef_addr   (coef_addr),
        .coef_a      (coef_a),
        .coef_b      (coef_b),
        .bn_en       (bn_en),
        .bn_din      (bn_din),
        .bn_a        (bn_a),
        .bn_b        (bn_b),
        .bn_o_valid  (bn_o_valid),
        .bn_dout     (bn_dout),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Coefficient RAM: one-cycle read latency.
    logic [D_WL-1:0] ram_a [256];
    logic [D_WL-1:0] ram_b [256];
    always @(posedge CLK) begin
        if (coef_rd) begin
            coef_a <= ram_a[coef_addr];
            coef_b <= ram_b[coef_addr];
        end
    end

    // BN unit: y = (x*A >>> 16) + B, Q.16, BN_LAT cycles.
    function automatic logic [D_WL-1:0] bn_calc(input logic signed [D_WL-1:0] x,
                                                input logic signed [D_WL-1:0] a,
                                                input logic signed [D_WL-1:0] b);
        logic signed [2*D_WL-1:0] p;
        p = x * a;
        return p[D_WL+15:16] + b;
    endfunction

    logic [2:0]      pv;
    logic [D_WL-1:0] pd0, pd1, pd2;
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv  <= {pv[1:0], bn_en};
            pd0 <= bn_calc(bn_din, bn_a, bn_b);
            pd1 <= pd0;
            pd2 <= pd1;
        end
    end
    assign bn_o_valid = pv[2];
    assign bn_dout    = pd2;

    // Monitor: cycle-stamped event logs, sampled on the falling edge.
    int              busy_q[$], done_q[$], crd_c[$], en_q[$], oc_q[$], uf_q[$];
    logic [CH_W-1:0] crd_a[$];
    logic [D_WL-1:0] od_q[$];
    logic            ol_q[$];
    always @(negedge CLK) begin
        if (rst_n) begin
            if (busy) busy_q.push_back(cyc);
            if (done) done_q.push_back(cyc);
            if (bn_en) en_q.push_back(cyc);
            if (coef_rd) begin
                crd_c.push_back(cyc);
                crd_a.push_back(coef_addr);
            end
            if (out_valid) begin
                od_q.push_back(out_data);
                ol_q.push_back(out_last);
                oc_q.push_back(cyc);
            end
            if (bn_o_valid && dut.inflight_q == '0) uf_q.push_back(cyc);
        end
    end

    typedef struct {
        logic [D_WL-1:0] din;
        logic [D_WL-1:0] dout;
        logic            last;
    } vec_t;
    vec_t tbl[6];

    int              nvec = 0;
    int              nfail = 0;
    int              start_cyc;
    int              feed_idx;
    logic [D_WL-1:0] pix_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        busy_q.delete(); done_q.delete(); crd_c.delete(); crd_a.delete();
        en_q.delete(); od_q.delete(); ol_q.delete(); oc_q.delete();
    endtask

    task automatic start_job(input int ch, input int pix);
        @(posedge CLK); #1;
        start       = 1'b1;
        cfg_ch_num  = ch[CH_W-1:0];
        cfg_pix_num = pix[PIX_W-1:0];
        start_cyc   = cyc;
    endtask

    task automatic feed_step(input bit toggle, input int k);
        @(posedge CLK); #1;
        start = 1'b0;
        if (feed_idx < pix_q.size()) begin
            in_valid = toggle ? (k % 2 == 0) : 1'b1;
            in_data  = pix_q[feed_idx];
        end else begin
            in_valid = 1'b0;
            in_data  = '0;
        end
        if (in_valid && in_ready) feed_idx++;
    endtask

    task automatic run_job(input int ch, input int pix, input bit toggle, input bit restart);
        int k;
        int tail;
        clear_mon();
        feed_idx = 0;
        k        = 0;
        tail     = -1;
        start_job(ch, pix);
        while (k < 300 && tail != 0) begin
            feed_step(toggle, k);
            if (restart && k == 3) begin
                start       = 1'b1;
                cfg_ch_num  = 1;
                cfg_pix_num = 1;
            end
            if (tail > 0) tail--;
            else if (tail < 0 && done_q.size() > 0) tail = 4;
            k++;
        end
        in_valid = 1'b0;
        check("done_count", done_q.size(), 1);
    endtask

    task automatic compare_table(input string tag);
        check({tag, "_n_results"}, od_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < od_q.size()) begin
                check($sformatf("%s_data[%0d]", tag, i), od_q[i], tbl[i].dout);
                check($sformatf("%s_last[%0d]", tag, i), ol_q[i], tbl[i].last);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        cfg_ch_num  = '0;
        cfg_pix_num = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        for (int i = 0; i < 256; i++) begin
            ram_a[i] = '0;
            ram_b[i] = '0;
        end
        ram_a[0] = 24'h010000; ram_b[0] = 24'h000000;
        ram_a[1] = 24'h020000; ram_b[1] = 24'h010000;

        tbl[0] = '{24'h010000, 24'h010000, 1'b0};
        tbl[1] = '{24'h020000, 24'h020000, 1'b0};
        tbl[2] = '{24'h030000, 24'h030000, 1'b0};
        tbl[3] = '{24'h010000, 24'h030000, 1'b0};
        tbl[4] = '{24'h020000, 24'h050000, 1'b0};
        tbl[5] = '{24'h030000, 24'h070000, 1'b1};

        repeat (3) @(posedge CLK);
        #1 rst_n = 1'b1;
        @(negedge CLK);
        check("reset_ctrl", {26'd0, busy, done, in_ready, coef_rd, bn_en, out_last}, 32'd0);
        check("reset_coef_addr", coef_addr, 32'd0);
        check("reset_bn_a", bn_a, 32'd0);
        check("reset_bn_b", bn_b, 32'd0);

        // Zero channel count: immediate done, nothing issued.
        pix_q.delete();
        run_job(0, 5, 1'b0, 1'b0);
        check("zero_done_latency", done_q[0] - start_cyc, 1);
        check("zero_busy_cycles", busy_q.size(), 1);
        check("zero_bn_en", en_q.size(), 0);
        check("zero_coef_rd", crd_c.size(), 0);
        check("zero_results", od_q.size(), 0);

        // 2x3 job, in_valid held high.
        pix_q.delete();
        for (int i = 0; i < 6; i++) pix_q.push_back(tbl[i].din);
        run_job(2, 3, 1'b0, 1'b0);
        compare_table("held");
        check("held_coef_rd_n", crd_c.size(), 2);
        check("held_coef_addr0", crd_a[0], 0);
        check("held_coef_addr1", crd_a[1], 1);
        check("held_coef_rd0_cyc", crd_c[0] - start_cyc, 1);
        check("held_ch_switch", crd_c[1] - crd_c[0], 2 + 3);
        // Formula counts start and done cycles inclusively.
        check("held_job_time", done_q[0] - start_cyc + 1, 1 + 2 * (2 + 3) + BN_LAT + 1);
        check("held_done_after_last", done_q[0] - oc_q[5], 1);
        check("held_busy_cycles", busy_q.size(), done_q[0] - start_cyc);
        check("held_bn_en_n", en_q.size(), 6);

        // Same job, in_valid toggling.
        run_job(2, 3, 1'b1, 1'b0);
        compare_table("toggle");
        check("toggle_bn_en_n", en_q.size(), 6);

        // Start pulse with a different config during RUN must be ignored.
        run_job(2, 3, 1'b0, 1'b1);
        compare_table("restart");
        check("restart_coef_rd_n", crd_c.size(), 2);

        // Abort mid-RUN after two accepted pixels, then a 1x1 job.
        clear_mon();
        feed_idx = 0;
        start_job(2, 3);
        for (int k = 0; k < 20 && feed_idx < 2; k++) feed_step(1'b0, k);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("abort_busy", {30'd0, busy, in_ready}, 32'd0);
        repeat (2) @(posedge CLK);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge CLK);
        check("abort_no_done", done_q.size(), 0);
        pix_q.delete();
        pix_q.push_back(24'h020000);
        run_job(1, 1, 1'b0, 1'b0);
        check("post_abort_n", od_q.size(), 1);
        check("post_abort_data", od_q[0], 24'h020000);
        check("post_abort_last", ol_q[0], 1);

        // Negative BN result: clamped by ReLU when fused.
        ram_a[0] = 24'h010000;
        ram_b[0] = 24'hFF0000;
        pix_q.delete();
        pix_q.push_back(24'h008000);
        run_job(1, 1, 1'b0, 1'b0);
        check("relu_n", od_q.size(), 1);
`ifdef BN_RELU_EN
        check("relu_data", od_q[0], 24'h000000);
`else
        check("relu_data", od_q[0], 24'hFF8000);
`endif
        check("relu_last", ol_q[0], 1);

        check("inflight_underflow", uf_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
